// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: 3-stage streaming posit decoder (sign, scale, fraction, zero/NaR flags).
// Optional NaR/zero statistics counters are enabled by defining POSIT_DECODE_STATS_EN.
`timescale 1ns/1ps
`default_nettype none

module posit_decode_pipe #(
   parameter int POSIT_WIDTH = 32,
   parameter int POSIT_ES    = 2,
   localparam int SCALE_WIDTH = $clog2(POSIT_WIDTH) + POSIT_ES + 1,
   localparam int FRAC_WIDTH  = POSIT_WIDTH - POSIT_ES - 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [POSIT_WIDTH-1:0] posit_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic                   sign_o,
   output logic [SCALE_WIDTH-1:0] scale_o,
   output logic [FRAC_WIDTH-1:0]  fraction_o,
   output logic                   zero_o,
   output logic                   nar_o
`ifdef POSIT_DECODE_STATS_EN
   ,
   output logic [15:0]            nar_count_o,
   output logic [15:0]            zero_count_o
`endif
);

   localparam int N     = POSIT_WIDTH;
   localparam int RUN_W = $clog2(POSIT_WIDTH) + 1;
   localparam int REM_W = POSIT_WIDTH - 3;

   logic s1_load, s2_load, s3_load;

   logic             s1_valid, s1_sign, s1_zero, s1_nar;
   logic [N-2:0]     s1_body;
   logic             s2_valid, s2_sign, s2_zero, s2_nar;
   logic signed [SCALE_WIDTH-1:0] s2_k;
   logic [REM_W-1:0] s2_rem;

   assign s3_load    = ~out_valid_o | out_ready_i;
   assign s2_load    = ~s2_valid | s3_load;
   assign s1_load    = ~s1_valid | s2_load;
   assign in_ready_o = s1_load;

   // Low N-1 bits of the two's-complement magnitude equal the negation of the low bits.
   logic [N-2:0] body_in;
   logic         is_zero, is_nar;
   assign body_in = posit_i[N-1] ? -posit_i[N-2:0] : posit_i[N-2:0];
   assign is_zero = (posit_i == '0);
   assign is_nar  = posit_i[N-1] & (posit_i[N-2:0] == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_zero  <= 1'b0;
         s1_nar   <= 1'b0;
         s1_body  <= '0;
      end else if (s1_load) begin
         s1_valid <= in_valid_i;
         if (in_valid_i) begin
            s1_sign <= posit_i[N-1];
            s1_zero <= is_zero;
            s1_nar  <= is_nar;
            s1_body <= body_in;
         end
      end
   end

   logic [RUN_W-1:0]       run_len;
   logic                   run_on;
   logic [SCALE_WIDTH-1:0] run_ext;
   logic signed [SCALE_WIDTH-1:0] k_next;
   logic [REM_W-1:0]       rem_next;

   always_comb begin
      run_len = '0;
      run_on  = 1'b1;
      for (int i = N - 2; i >= 0; i--) begin
         if (run_on && (s1_body[i] == s1_body[N-2])) begin
            run_len = run_len + RUN_W'(1);
         end else begin
            run_on = 1'b0;
         end
      end
   end

   assign run_ext = SCALE_WIDTH'(run_len);
   assign k_next  = s1_body[N-2] ? $signed(run_ext - SCALE_WIDTH'(1)) : -$signed(run_ext);
   // Dropping the first run bit and the terminator turns a shift of m+1 into m-1 on body[N-4:0].
   assign rem_next = s1_body[N-4:0] << (run_len - RUN_W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_zero  <= 1'b0;
         s2_nar   <= 1'b0;
         s2_k     <= '0;
         s2_rem   <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_nar  <= s1_nar;
            s2_k    <= k_next;
            s2_rem  <= rem_next;
         end
      end
   end

   logic [SCALE_WIDTH-1:0]        e_ext;
   logic signed [SCALE_WIDTH-1:0] scale_next;

   generate
      if (POSIT_ES > 0) begin : g_exp
         assign e_ext = SCALE_WIDTH'(s2_rem[REM_W-1 -: POSIT_ES]);
      end else begin : g_no_exp
         assign e_ext = '0;
      end
   endgenerate

   assign scale_next = (s2_k <<< POSIT_ES) + $signed(e_ext);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_o <= 1'b0;
         sign_o      <= 1'b0;
         scale_o     <= '0;
         fraction_o  <= '0;
         zero_o      <= 1'b0;
         nar_o       <= 1'b0;
      end else if (s3_load) begin
         out_valid_o <= s2_valid;
         if (s2_valid) begin
            sign_o <= s2_sign;
            zero_o <= s2_zero;
            nar_o  <= s2_nar;
            if (s2_zero || s2_nar) begin
               scale_o    <= '0;
               fraction_o <= '0;
            end else begin
               scale_o    <= scale_next;
               fraction_o <= s2_rem[FRAC_WIDTH-1:0];
            end
         end
      end
   end

`ifdef POSIT_DECODE_STATS_EN
   logic out_fire;
   assign out_fire = out_valid_o & out_ready_i;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         nar_count_o  <= '0;
         zero_count_o <= '0;
      end else if (out_fire) begin
         if (nar_o && (nar_count_o != 16'hFFFF)) begin
            nar_count_o <= nar_count_o + 16'd1;
         end
         if (zero_o && (zero_count_o != 16'hFFFF)) begin
            zero_count_o <= zero_count_o + 16'd1;
         end
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_posit_decode_pipe.sv
// Self-checking bench for posit_decode_pipe: directed cases, random handshaked stream, backpressure, reset.
`timescale 1ns/1ps
`default_nettype none

module tb_posit_decode_pipe;

   localparam int N  = 32;
   localparam int ES = 2;
   localparam int SW = $clog2(N) + ES + 1;
   localparam int FW = N - ES - 3;
   localparam int RW = 1 + SW + FW + 2;
   localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

   logic          clk;
   logic          rst_n;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [N-1:0]  posit_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic          sign_o;
   logic [SW-1:0] scale_o;
   logic [FW-1:0] fraction_o;
   logic          zero_o;
   logic          nar_o;
`ifdef POSIT_DECODE_STATS_EN
   logic [15:0]   nar_count_o;
   logic [15:0]   zero_count_o;
`endif

   posit_decode_pipe #(.POSIT_WIDTH(N), .POSIT_ES(ES)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .posit_i     (posit_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .sign_o      (sign_o),
      .scale_o     (scale_o),
      .fraction_o  (fraction_o),
      .zero_o      (zero_o),
      .nar_o       (nar_o)
`ifdef POSIT_DECODE_STATS_EN
      ,
      .nar_count_o (nar_count_o),
      .zero_count_o(zero_count_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [RW-1:0] exp_q[$];
   logic          stall_prev = 1'b0;
   logic [RW-1:0] held;
   logic [RW-1:0] obs;
   assign obs = {sign_o, scale_o, fraction_o, zero_o, nar_o};

   // Reference decoder: walks the bit string of |p| with integer arithmetic.
   function automatic logic [RW-1:0] ref_decode(input logic [N-1:0] p);
      longint x, r0, rembits, frac;
      int m, k, rem, e, fbits, scale;
      logic s;
      if (p == '0) return {1'b0, SW'(0), FW'(0), 1'b1, 1'b0};
      if (p == NAR) return {1'b1, SW'(0), FW'(0), 1'b0, 1'b1};
      s = p[N-1];
      x = s ? ((longint'(1) << N) - longint'(p)) : longint'(p);
      r0 = (x >> (N - 2)) & 1;
      m = 0;
      while (m < N - 1 && ((x >> (N - 2 - m)) & 1) == r0) m++;
      k = (r0 == 1) ? m - 1 : -m;
      rem = N - 2 - m;
      if (rem < 0) rem = 0;
      rembits = x & ((longint'(1) << rem) - 1);
      if (rem >= ES) begin
         e = int'(rembits >> (rem - ES));
         fbits = rem - ES;
         frac = (rembits & ((longint'(1) << fbits) - 1)) << (FW - fbits);
      end else begin
         e = int'(rembits << (ES - rem));
         frac = 0;
      end
      scale = k * (1 << ES) + e;
      return {s, SW'(scale), FW'(frac), 2'b00};
   endfunction

   function automatic logic [N-1:0] rand_word();
      logic [N-1:0] x;
      case ($urandom_range(0, 9))
         0: x = '0;
         1: x = NAR;
         2: x = 32'h7FFF_FFFF;
         3: x = 32'h0000_0001;
         4, 5: begin
            x = $urandom >> $urandom_range(0, 30);
            if ($urandom_range(0, 1) == 1) x = -x;
         end
         default: x = $urandom;
      endcase
      return x;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, score handshakes just after.
   task automatic cycle(input logic v, input logic [N-1:0] p, input logic rdy);
      @(negedge clk);
      in_valid_i  = v;
      posit_i     = p;
      out_ready_i = rdy;
      #1;
      if (stall_prev) begin
         check("stall_valid", 64'(out_valid_o), 64'd1);
         check("stall_hold", 64'(obs), 64'(held));
      end
      if (out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) check("spurious_out", 64'(out_valid_o), 64'd0);
         else check("result", 64'(obs), 64'(exp_q.pop_front()));
      end
      if (in_valid_i && in_ready_o) exp_q.push_back(ref_decode(posit_i));
      stall_prev = out_valid_o && !out_ready_i;
      held = obs;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid_i = 1'b0;
      out_ready_i = 1'b0;
      @(negedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid_o), 64'd0);
      check("rst_outputs", 64'(obs), 64'd0);
      check("rst_in_ready", 64'(in_ready_o), 64'd1);
      rst_n = 1'b1;
      exp_q.delete();
      stall_prev = 1'b0;
   endtask

   task automatic directed(input logic [N-1:0] p, input logic es, input int esc,
                           input logic ez, input logic en);
      logic [SW-1:0] sc;
      sc = SW'(esc);
      cycle(1'b1, p, 1'b1);
      cycle(1'b0, '0, 1'b1); check("lat_c1", 64'(out_valid_o), 64'd0);
      cycle(1'b0, '0, 1'b1); check("lat_c2", 64'(out_valid_o), 64'd0);
      cycle(1'b0, '0, 1'b1); check("lat_c3", 64'(out_valid_o), 64'd1);
      check("sign", 64'(sign_o), 64'(es));
      check("scale", 64'(scale_o), 64'(sc));
      check("fraction", 64'(fraction_o), 64'd0);
      check("zero", 64'(zero_o), 64'(ez));
      check("nar", 64'(nar_o), 64'(en));
   endtask

   int accepted;
   logic [N-1:0] pend;
   logic rv, rr;

   initial begin
      rst_n = 1'b0;
      in_valid_i = 1'b0;
      posit_i = '0;
      out_ready_i = 1'b0;
      do_reset();

      directed(32'h4000_0000, 1'b0,    0, 1'b0, 1'b0);
      directed(32'h4800_0000, 1'b0,    1, 1'b0, 1'b0);
      directed(32'hC000_0000, 1'b1,    0, 1'b0, 1'b0);
      directed(32'h7FFF_FFFF, 1'b0,  120, 1'b0, 1'b0);
      directed(32'h0000_0001, 1'b0, -120, 1'b0, 1'b0);
      directed(32'h0000_0000, 1'b0,    0, 1'b1, 1'b0);
      directed(32'h8000_0000, 1'b1,    0, 1'b0, 1'b1);

      // Random stream with independent random valid and ready.
      accepted = 0;
      pend = rand_word();
      for (int c = 0; c < 3000 && accepted < 100; c++) begin
         rv = 1'($urandom_range(0, 1));
         rr = 1'($urandom_range(0, 1));
         cycle(rv, pend, rr);
         if (rv && in_ready_o) begin
            accepted++;
            pend = rand_word();
         end
      end
      check("stream_accepted", 64'(accepted), 64'd100);
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) cycle(1'b0, '0, 1'b1);
      check("stream_drained", 64'(exp_q.size()), 64'd0);

      // Backpressure: fill three stages, then release.
      do_reset();
      cycle(1'b1, 32'h5000_0000, 1'b0);
      cycle(1'b1, 32'hB123_4567, 1'b0);
      cycle(1'b1, 32'h0000_0003, 1'b0);
      cycle(1'b1, 32'h2222_2222, 1'b0);
      check("bp_full_ready", 64'(in_ready_o), 64'd0);
      check("bp_full_valid", 64'(out_valid_o), 64'd1);
      cycle(1'b0, '0, 1'b1);
      check("bp_release_ready", 64'(in_ready_o), 64'd1);
      check("bp_out1", 64'(out_valid_o), 64'd1);
      cycle(1'b0, '0, 1'b1); check("bp_out2", 64'(out_valid_o), 64'd1);
      cycle(1'b0, '0, 1'b1); check("bp_out3", 64'(out_valid_o), 64'd1);
      cycle(1'b0, '0, 1'b1); check("bp_empty", 64'(out_valid_o), 64'd0);
      check("bp_drained", 64'(exp_q.size()), 64'd0);

      // Reset with three words in flight drops them all.
      cycle(1'b1, 32'h6000_0000, 1'b0);
      cycle(1'b1, 32'h1234_5678, 1'b0);
      cycle(1'b1, 32'h9ABC_DEF0, 1'b0);
      do_reset();
      for (int c = 0; c < 6; c++) begin
         cycle(1'b0, '0, 1'b1);
         check("post_rst_quiet", 64'(out_valid_o), 64'd0);
      end

`ifdef POSIT_DECODE_STATS_EN
      do_reset();
      check("cnt_nar_rst", 64'(nar_count_o), 64'd0);
      cycle(1'b1, NAR, 1'b1);
      cycle(1'b1, NAR, 1'b1);
      cycle(1'b1, NAR, 1'b1);
      cycle(1'b1, '0, 1'b1);
      for (int c = 0; c < 6; c++) cycle(1'b0, '0, 1'b1);
      check("cnt_nar", 64'(nar_count_o), 64'd3);
      check("cnt_zero", 64'(zero_count_o), 64'd1);
      do_reset();
      check("cnt_nar_clr", 64'(nar_count_o), 64'd0);
      check("cnt_zero_clr", 64'(zero_count_o), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/posit_decode_pipe.md
Name: posit_decode_pipe

Overview:
Streaming posit decoder: unpacks a POSIT_WIDTH-bit posit word into sign, signed scale, fraction (hidden bit excluded), zero and NaR flags. It is the inverse of the posit normalize/encode stage and sits at the input side of posit arithmetic datapaths. The block is a 3-stage pipeline with valid/ready handshakes on both sides, one word per cycle throughput, and full backpressure support.

Parameters:
POSIT_WIDTH, 32, posit word width N (>=8)
POSIT_ES, 2, exponent field width ES (>=0)
SCALE_WIDTH, $clog2(POSIT_WIDTH)+POSIT_ES+1, signed scale width (derived, not overridden)
FRAC_WIDTH, POSIT_WIDTH-POSIT_ES-3, fraction width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid_i  in  1  input word valid
in_ready_o  out  1  decoder can accept a word
posit_i  in  POSIT_WIDTH  posit word
out_valid_o  out  1  decoded result valid
out_ready_i  in  1  consumer accepts the result
sign_o  out  1  sign bit
scale_o  out  SCALE_WIDTH  two's-complement scale, k*2^ES+e
fraction_o  out  FRAC_WIDTH  fraction, MSB-aligned, zero-padded
zero_o  out  1  input was 0
nar_o  out  1  input was NaR (1 followed by zeros)

Behaviour:
- Reset: all stage valid bits 0. out_valid_o=0, sign_o=0, scale_o=0, fraction_o=0, zero_o=0, nar_o=0. in_ready_o=1 in the first cycle after reset. A reset mid-stream silently drops all in-flight words.
- Handshake: a transfer occurs when valid and ready are both 1 on a rising edge. A stage advances when it is empty or the downstream stage is advancing. in_ready_o = ~s1_valid | s1_advance. A combinational path from out_ready_i to in_ready_o is permitted.
- Latency: 3 cycles from the input transfer to out_valid_o with no stalls. Back-to-back words give 1 result per cycle.
- While out_valid_o=1 and out_ready_i=0, all outputs hold stable and no word is lost or duplicated.
- Stage 1 (capture):
  - zero = (posit==0); NaR = (posit=={1,0...}).
  - sign = posit[N-1]; mag = sign ? -posit : posit.
  - Register body = mag[N-2:0] and the flags.
- Stage 2 (regime):
  - r0 = body[N-2]; m = length of the leading run of bits equal to r0, range 1..N-1.
  - k = r0 ? m-1 : -m.
  - Register k, and body shifted left by m+1 (run plus terminator) with zero fill.
- Stage 3 (field extract):
  - e = top ES bits of the shifted body. Exponent bits truncated off the word read as 0.
  - fraction = the next FRAC_WIDTH bits.
  - scale = (k<<ES) + e, sign-extended to SCALE_WIDTH.
  - When ES=0, e is absent and scale=k.
- Special cases: when zero_o or nar_o is 1, sign_o=0 for zero and 1 for NaR; scale_o=0 and fraction_o=0 in both cases.
- Boundaries:
  - maxpos: m=N-1, k=N-2, no terminator bit present.
  - minpos: k=-(N-2).
  - The scale range ±(N-2)*2^ES fits SCALE_WIDTH.

Optional Feature:
Macro POSIT_DECODE_STATS_EN.
- Defined: adds outputs nar_count_o [15:0] and zero_count_o [15:0].
  - Each counter increments by 1 on every output transfer with nar_o or zero_o set.
  - Both counters saturate at 16'hFFFF and reset to 0 on rst_n=0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- N=32, ES=2, input 0x40000000 -> sign 0, scale 0, fraction 0, zero 0, nar 0; out_valid_o asserted exactly 3 cycles after the input transfer.
- Input 0x48000000 -> scale 1, fraction 0. Input 0xC0000000 -> sign 1, scale 0, fraction 0.
- Input 0x7FFFFFFF -> scale 120, fraction 0. Input 0x00000001 -> scale -120, fraction 0. Input 0x00000000 -> zero 1. Input 0x80000000 -> nar 1, sign 1.
- Stream 100 random words with in_valid_i and out_ready_i randomly toggled (50% each) -> results match a software decoder, in order, with no drops or duplicates; outputs stay stable during stalls.
- Fill the pipeline, then hold out_ready_i=0 -> in_ready_o=0 once 3 words are in flight. Release it -> 1 result/cycle and in_ready_o=1 in the same cycle.
- Assert rst_n=0 with 3 words in flight -> out_valid_o=0 the next cycle and no stale word appears afterwards. With POSIT_DECODE_STATS_EN defined, 3 NaR inputs -> nar_count_o=3, then reset -> 0.
